// File: rtl/seg7_pkg.sv
// Shared constants and lookup for reading back an active-low 7-segment bus.
// Segment order is {a,b,c,d,e,f,g}, bit 6 = a.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b1100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b1110010;
  localparam logic [6:0] SEG_B     = 7'b1100110;
  localparam logic [6:0] SEG_C     = 7'b1011100;
  localparam logic [6:0] SEG_D     = 7'b0110100;
  localparam logic [6:0] SEG_E     = 7'b1110000;
  localparam logic [6:0] SEG_F     = 7'b1111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

  // Returns {valid, value}; the all-off pattern decodes as F (and is also blank).
  function automatic logic [4:0] seg_to_hex(input logic [6:0] pattern);
    case (pattern)
      SEG_0:   return {1'b1, 4'h0};
      SEG_1:   return {1'b1, 4'h1};
      SEG_2:   return {1'b1, 4'h2};
      SEG_3:   return {1'b1, 4'h3};
      SEG_4:   return {1'b1, 4'h4};
      SEG_5:   return {1'b1, 4'h5};
      SEG_6:   return {1'b1, 4'h6};
      SEG_7:   return {1'b1, 4'h7};
      SEG_8:   return {1'b1, 4'h8};
      SEG_9:   return {1'b1, 4'h9};
      SEG_A:   return {1'b1, 4'hA};
      SEG_B:   return {1'b1, 4'hB};
      SEG_C:   return {1'b1, 4'hC};
      SEG_D:   return {1'b1, 4'hD};
      SEG_E:   return {1'b1, 4'hE};
      SEG_F:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to hex lookup; also reusable by checkers.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       valid
);

  logic [4:0] hex;

  assign hex   = seg_to_hex(pattern);
  assign valid = hex[4];
  assign value = hex[3:0];

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and recovers each digit once
// its anode/segment sample has been stable for STABLE_CNT synchronized cycles.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              a_to_g,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    frame_done
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [CW-1:0]         CNT_MAX = CW'(STABLE_CNT);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

  logic [SW-1:0] sync_reg, s_reg, prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '1;
      s_reg    <= '1;
      prev_reg <= '1;
    end else begin
      sync_reg <= {an, a_to_g};
      s_reg    <= sync_reg;
      prev_reg <= s_reg;
    end
  end

  logic [NUM_DIGITS-1:0] sel_low;
  logic [6:0]            s_seg;
  logic                  sel_valid;
  logic [IW-1:0]         sel_idx;

  assign sel_low   = ~s_reg[SW-1:7];
  assign s_seg     = s_reg[6:0];
  // Exactly one anode low: nonzero and a power of two.
  assign sel_valid = (sel_low != '0) && ((sel_low & (sel_low - DIG_ONE)) == '0);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_low[i]) sel_idx = IW'(i);
    end
  end

  logic [3:0] dec_value;
  logic       dec_valid;

  seg7_pattern_decode u_decode (
    .pattern (s_seg),
    .value   (dec_value),
    .valid   (dec_valid)
  );

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          commit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= WAIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    case (state_reg)
      WAIT: begin
        if (sel_valid) begin
          state_next = SETTLE;
          cnt_next   = CNT_ONE;
        end
      end
      SETTLE: begin
        if (!sel_valid) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else if (s_reg != prev_reg) begin
          cnt_next = CNT_ONE;
        end else begin
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNT_ONE;
          if (cnt_next == CNT_MAX) begin
            commit     = 1'b1;
            state_next = HELD;
          end
        end
      end
      HELD: begin
        // A steady sample stays here so each dwell commits only once.
        if (!sel_valid) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else if (s_reg != prev_reg) begin
          state_next = SETTLE;
          cnt_next   = CNT_ONE;
        end
      end
      default: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
    endcase
  end

  logic [4*NUM_DIGITS-1:0] digits_reg;
  logic [NUM_DIGITS-1:0]   blank_reg, err_reg, seen_reg, seen_or;
  logic                    frame_done_reg, frame_complete;

  assign seen_or        = seen_reg | (DIG_ONE << sel_idx);
  assign frame_complete = commit && (seen_or == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_reg     <= '0;
      blank_reg      <= '1;
      err_reg        <= '0;
      seen_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_complete;
      if (commit) begin
        if (dec_valid) begin
          digits_reg[int'(sel_idx)*4 +: 4] <= dec_value;
          err_reg[sel_idx]                 <= 1'b0;
          blank_reg[sel_idx]               <= (s_seg == SEG_BLANK);
        end else begin
          err_reg[sel_idx] <= 1'b1;
        end
        seen_reg <= frame_complete ? '0 : seen_or;
      end
    end
  end

  assign digits     = digits_reg;
  assign blank      = blank_reg;
  assign err        = err_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: table of held bus states with a
// scoreboard of expected outputs, plus hand sequences for latency and reset.
module tb_seg7_scan_decoder;

  logic        clk;
  logic        reset_n;
  logic [3:0]  an;
  logic [6:0]  a_to_g;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        frame_done;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .an         (an),
    .a_to_g     (a_to_g),
    .digits     (digits),
    .blank      (blank),
    .err        (err),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int fails  = 0;

  // Pulse counter, sampled just after each rising edge.
  int          frame_cnt = 0;
  logic [15:0] frame_digits = '0;
  always @(posedge clk) begin
    #1;
    if (frame_done) begin
      frame_cnt++;
      frame_digits = digits;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          cycles;
    logic [15:0] exp_digits;
    logic [3:0]  exp_blank;
    logic [3:0]  exp_err;
    int          exp_frames;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic add(input logic [3:0] a, input logic [6:0] g, input int cyc,
                     input logic [15:0] d, input logic [3:0] b, input logic [3:0] e,
                     input int f);
    vec_t v;
    v.an = a; v.seg = g; v.cycles = cyc;
    v.exp_digits = d; v.exp_blank = b; v.exp_err = e; v.exp_frames = f;
    tbl.push_back(v);
  endtask

  initial begin
    int first;
    int f0;
    vec_t exp_v;

    // Expected state after each held bus value, written out by hand.
    add(4'b1110, 7'b0010010, 10, 16'h0002, 4'b1110, 4'b0000, 0);
    add(4'b1110, 7'b1001111, 10, 16'h0001, 4'b1110, 4'b0000, 0);
    add(4'b1101, 7'b0010010, 10, 16'h0021, 4'b1100, 4'b0000, 0);
    add(4'b1011, 7'b0000110, 10, 16'h0321, 4'b1000, 4'b0000, 0);
    add(4'b0111, 7'b1001100, 10, 16'h4321, 4'b0000, 4'b0000, 1);
    add(4'b1110, 7'b1001111, 10, 16'h4321, 4'b0000, 4'b0000, 0);
    add(4'b1101, 7'b0010010, 10, 16'h4321, 4'b0000, 4'b0000, 0);
    add(4'b1011, 7'b0000110, 10, 16'h4321, 4'b0000, 4'b0000, 0);
    add(4'b0111, 7'b1001100, 10, 16'h4321, 4'b0000, 4'b0000, 1);
    add(4'b1111, 7'b1111111, 10, 16'h4321, 4'b0000, 4'b0000, 0);
    add(4'b1101, 7'b0000110,  3, 16'h4321, 4'b0000, 4'b0000, 0);
    add(4'b1111, 7'b0000110, 10, 16'h4321, 4'b0000, 4'b0000, 0);
    add(4'b1110, 7'b1001111, 10, 16'h4321, 4'b0000, 4'b0000, 0);
    add(4'b1011, 7'b1111110, 10, 16'h4321, 4'b0000, 4'b0100, 0);
    add(4'b1011, 7'b1111111, 10, 16'h4F21, 4'b0100, 4'b0000, 0);
    add(4'b0111, 7'b0001111, 10, 16'h7F21, 4'b0100, 4'b0000, 0);
    add(4'b1101, 7'b1110000, 10, 16'h7FE1, 4'b0100, 4'b0000, 1);
    add(4'b1100, 7'b0100100, 10, 16'h7FE1, 4'b0100, 4'b0000, 0);
    add(4'b1110, 7'b0000000, 10, 16'h7FE8, 4'b0100, 4'b0000, 0);
    add(4'b1110, 7'b1110010, 10, 16'h7FEA, 4'b0100, 4'b0000, 0);
    add(4'b1110, 7'b0110100, 10, 16'h7FED, 4'b0100, 4'b0000, 0);
    add(4'b1110, 7'b0000001, 10, 16'h7FE0, 4'b0100, 4'b0000, 0);

    // Reset with the bus idle.
    reset_n = 1'b0;
    an      = 4'b1111;
    a_to_g  = 7'b1111111;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_digits", 32'(digits), 32'h0000);
    check("reset_blank", 32'(blank), 32'hF);
    check("reset_err", 32'(err), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    check("reset_no_frames", 32'(frame_cnt), 32'd0);
    $display("reset idle: digits=%h blank=%b err=%b", digits, blank, err);

    // Commit latency: first visible change on the 6th rising edge.
    an     = 4'b1110;
    a_to_g = 7'b0010010;
    first  = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (first == 0 && digits[3:0] == 4'h2) first = c;
    end
    check("commit_latency", 32'(first), 32'd6);
    $display("latency: digit0 committed on edge %0d", first);

    // Table rows through the scoreboard.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      an     = tbl[i].an;
      a_to_g = tbl[i].seg;
      sb.push_back(tbl[i]);
      f0 = frame_cnt;
      repeat (tbl[i].cycles - 1) @(negedge clk);
      exp_v = sb.pop_front();
      check($sformatf("row%0d_digits", i), 32'(digits), 32'(exp_v.exp_digits));
      check($sformatf("row%0d_blank", i), 32'(blank), 32'(exp_v.exp_blank));
      check($sformatf("row%0d_err", i), 32'(err), 32'(exp_v.exp_err));
      check($sformatf("row%0d_frames", i), 32'(frame_cnt - f0), 32'(exp_v.exp_frames));
      if (exp_v.exp_frames == 1)
        check($sformatf("row%0d_frame_digits", i), 32'(frame_digits), 32'(exp_v.exp_digits));
      $display("row %0d: an=%b seg=%b digits=%h blank=%b err=%b frames=%0d",
               i, an, a_to_g, digits, blank, err, frame_cnt - f0);
    end

    // Ghosted select, then reset mid-settle at cnt = 2.
    @(negedge clk);
    an     = 4'b1100;
    a_to_g = 7'b0001100;
    repeat (10) @(negedge clk);
    check("ghost_digits", 32'(digits), 32'h7FE0);
    an = 4'b1101;
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_digits", 32'(digits), 32'h0000);
    check("async_rst_blank", 32'(blank), 32'hF);
    check("async_rst_err", 32'(err), 32'h0);
    check("async_rst_frame_done", 32'(frame_done), 32'h0);
    $display("async reset: digits=%h blank=%b err=%b", digits, blank, err);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    f0 = frame_cnt;
    @(negedge clk);
    check("post_rst_no_partial", 32'(digits), 32'h0000);
    repeat (9) @(negedge clk);
    check("post_rst_digits", 32'(digits), 32'h0090);
    check("post_rst_blank", 32'(blank), 32'hD);
    check("post_rst_frames", 32'(frame_cnt - f0), 32'd0);
    $display("after reset rescan: digits=%h blank=%b", digits, blank);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
